fifo_rd_stream_adapter: RTL and testbench
=========================================

Name: fifo_rd_stream_adapter

Overview:
- Read-domain stage directly downstream of the async FIFO.
- Pops the FIFO via rinc/rempty/rdata and presents words on a valid/ready stream with a 2-entry skid buffer, so the output is fully registered.
- Sustains 1 word/cycle and counts delivered words.

Parameters:
- dw, 8, data width; must match the FIFO's dw.
- rd_lat, 0, FIFO read latency in rclk cycles (0: rdata valid in the rinc cycle; 1: rdata valid the cycle after rinc). Only 0 and 1 are legal.
- cw, 16, width of the delivered-word counter.

Ports:
- rclk  in  1  read-domain clock.
- rrst_n  in  1  asynchronous active-low reset.
- rempty  in  1  FIFO empty flag (rclk domain).
- rdata  in  dw  FIFO read data.
- rinc  out  1  FIFO pop request.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts.
- m_data  out  dw  output word.
- rd_count  out  cw  number of words accepted downstream, wraps modulo 2^cw.

Behaviour:
- One clock: rclk. Reset: rrst_n, asynchronous assert, active-low. Release must be synchronised externally.
- Reset values:
  - m_valid=0, m_data=0, rd_count=0.
  - Buffer state EMPTY, in-flight=0.
  - rinc=0 while rrst_n=0.
- Storage and states:
  - Two dw-bit entries (head, tail), both registered.
  - FSM states: EMPTY (occ=0), ONE (occ=1), TWO (occ=2).
- Output:
  - m_data = head entry; m_valid = (occ!=0). Both are register outputs.
- Handshakes:
  - acc = m_valid & m_ready.
  - m_data must stay stable while m_valid=1 and m_ready=0.
- Pop rule:
  - rinc = !rempty & (occ + inflight - acc < 2).
  - inflight is always 0 when rd_lat=0. When rd_lat=1, inflight = rinc registered one cycle.
  - The combinational path from m_ready to rinc is permitted.
- Capture:
  - rd_lat=0: rdata is written in the rinc cycle.
  - rd_lat=1: rdata is written in the cycle after rinc, i.e. while inflight=1.
  - The word goes to head if occ-acc==0, else to tail.
- State transitions (cap = a word is captured this cycle):
  - EMPTY: cap→ONE.
  - ONE: cap&!acc→TWO; !cap&acc→EMPTY; otherwise stay. On cap&acc, head is replaced by the new word.
  - TWO: acc→ONE with tail moved to head. cap is impossible in TWO without acc, by construction of the pop rule.
- Latency from rempty falling to m_valid rising: 1 cycle for rd_lat=0, 2 cycles for rd_lat=1.
- Throughput: 1 word/cycle in steady state with m_ready=1, for both rd_lat values.
- Back-pressure:
  - With m_ready=0, at most 2 words are buffered.
  - rinc deasserts once occ+inflight reaches 2.
  - No word is dropped or duplicated.
- rd_count increments by 1 on every acc and wraps from 2^cw-1 to 0.
- Boundary conditions:
  - rempty toggling every cycle: rinc is only ever asserted when rempty=0.
  - Simultaneous cap and acc in ONE: occ is unchanged and order is preserved.
  - Reset mid-transfer: the buffer is cleared and in-flight words are discarded. FIFO-side pointer recovery belongs to the FIFO's own reset, which must be applied together with this block's reset.
- Assertions:
  - No capture when occ=2.
  - m_data stable under stall.
  - rinc never asserted with rempty=1.

Decomposition:
- Package fifo_pkg:
  - typedef buf_state_e {EMPTY, ONE, TWO}.
  - Constant SKID_DEPTH=2.
- Sub-module: none. The skid buffer is small enough to stay inline.
- The FIFO is instantiated beside this block at the next level up, not inside it.

Test Plan:
- Reset, then FIFO preloaded with 0x11,0x22,0x33, m_ready=1, rd_lat=0 → m_valid rises 1 cycle after reset release; the stream is 0x11,0x22,0x33 on consecutive cycles; rd_count=3; rinc is pulsed exactly 3 times.
- Same stimulus with rd_lat=1 → first m_valid is 2 cycles after rempty=0, then 1 word/cycle; rd_count=3.
- FIFO holds 0x01..0x05, m_ready=0 for 6 cycles → exactly 2 pops occur, m_data holds 0x01 stable, rinc=0 afterwards. Releasing m_ready yields 0x01..0x05 in order with no gaps after the first.
- m_ready random 50% over 200 words 0x00..0xC7 → an in-order scoreboard passes with no loss or duplicates; rd_count=200.
- cw=4, 18 words delivered → rd_count wraps to 2.
- rrst_n asserted while occ=2 → m_valid=0, rd_count=0 and rinc=0 immediately (asynchronously). After release the adapter resumes from the next FIFO word.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side stream adapter: skid buffer states and depth.
package fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    localparam int SKID_DEPTH = 2;

    function automatic logic [1:0] occ_of(input buf_state_e s);
        case (s)
            ONE:     return 2'd1;
            TWO:     return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter.sv
// Pops the async FIFO into a registered 2-entry skid buffer driving a valid/ready stream; rempty-fall to m_valid is 1 cycle (rd_lat=0) or 2 (rd_lat=1).
// Back-pressure: at most two words held, popping stops once buffered plus in-flight words reach two; no word is dropped or duplicated.
module fifo_rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter int dw     = 8,
    parameter int rd_lat = 0,
    parameter int cw     = 16
) (
    input  logic          rclk,
    input  logic          rrst_n,
    input  logic          rempty,
    input  logic [dw-1:0] rdata,
    output logic          rinc,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [dw-1:0] m_data,
    output logic [cw-1:0] rd_count
);

    buf_state_e    r_state;
    logic [dw-1:0] r_head;
    logic [dw-1:0] r_tail;
    logic          r_valid;
    logic [cw-1:0] r_count;
    logic          r_inflight;

    logic [1:0]    w_occ;
    logic [2:0]    w_level;
    logic          w_acc;
    logic          w_pop_ok;
    logic          w_cap;

    assign w_occ    = occ_of(r_state);
    assign w_acc    = r_valid & m_ready;
    assign w_level  = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_acc};
    assign w_pop_ok = ~rempty & (w_level < 3'(SKID_DEPTH));
    // Reset only gates the output; the flops below are held by the async reset anyway.
    assign rinc     = rrst_n & w_pop_ok;

    generate
        if (rd_lat == 0) begin : g_lat0
            assign r_inflight = 1'b0;
            assign w_cap      = w_pop_ok;
        end else begin : g_lat1
            always_ff @(posedge rclk or negedge rrst_n) begin
                if (!rrst_n) begin
                    r_inflight <= 1'b0;
                end else begin
                    r_inflight <= w_pop_ok;
                end
            end
            assign w_cap = r_inflight;
        end
    endgenerate

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state <= EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_acc) begin
                r_count <= r_count + cw'(1);
            end
            case (r_state)
                EMPTY: begin
                    if (w_cap) begin
                        r_head  <= rdata;
                        r_state <= ONE;
                        r_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_cap && w_acc) begin
                        r_head <= rdata;
                    end else if (w_cap) begin
                        r_tail  <= rdata;
                        r_state <= TWO;
                    end else if (w_acc) begin
                        r_state <= EMPTY;
                        r_valid <= 1'b0;
                    end
                end
                TWO: begin
                    // A capture here only happens alongside an accept (rd_lat=0 refill).
                    if (w_acc) begin
                        r_head <= r_tail;
                        if (w_cap) begin
                            r_tail <= rdata;
                        end else begin
                            r_state <= ONE;
                        end
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign m_valid  = r_valid;
    assign m_data   = r_head;
    assign rd_count = r_count;

    a_no_overflow: assert property (@(posedge rclk) disable iff (!rrst_n)
        w_cap |-> ((w_occ != 2'd2) || w_acc));
    a_stall_stable: assert property (@(posedge rclk) disable iff (!rrst_n)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));
    a_no_pop_empty: assert property (@(posedge rclk) disable iff (!rrst_n)
        rinc |-> !rempty);

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: three instances (rd_lat=0, rd_lat=1, cw=4) fed by a queue-like FIFO model.
module tb_fifo_rd_stream_adapter;

    logic            rclk = 1'b0;
    logic            rrst_n;
    logic [2:0]      rempty;
    logic [2:0]      rinc;
    logic [2:0]      m_valid;
    logic [2:0]      m_ready;
    logic [2:0][7:0] rdata;
    logic [2:0][7:0] m_data;
    logic [15:0]     rd_count0;
    logic [15:0]     rd_count1;
    logic [3:0]      rd_count2;

    logic [7:0]      fmem [3][256];
    int              fwr [3];
    int              frd [3];
    logic [7:0]      rdata1_q;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] inst;
        logic       rdy;
        logic       e_rinc;
        logic       e_vld;
        logic       chk_dat;
        logic [7:0] e_dat;
    } vec_t;
    vec_t tbl [64];
    int   n_tbl = 0;

    int acc_cnt [3];
    int base [3];
    int viol = 0;
    int pulses;

    always #5 rclk = ~rclk;

    fifo_rd_stream_adapter #(.dw(8), .rd_lat(0), .cw(16)) u_dut0 (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty[0]), .rdata(rdata[0]), .rinc(rinc[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]), .rd_count(rd_count0));
    fifo_rd_stream_adapter #(.dw(8), .rd_lat(1), .cw(16)) u_dut1 (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty[1]), .rdata(rdata[1]), .rinc(rinc[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]), .rd_count(rd_count1));
    fifo_rd_stream_adapter #(.dw(8), .rd_lat(0), .cw(4)) u_dut2 (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty[2]), .rdata(rdata[2]), .rinc(rinc[2]),
        .m_valid(m_valid[2]), .m_ready(m_ready[2]), .m_data(m_data[2]), .rd_count(rd_count2));

    // FIFO model: words leave strictly in push order; instance 1 sees rdata one cycle after rinc.
    assign rempty[0] = (fwr[0] == frd[0]);
    assign rempty[1] = (fwr[1] == frd[1]);
    assign rempty[2] = (fwr[2] == frd[2]);
    assign rdata[0]  = fmem[0][frd[0][7:0]];
    assign rdata[1]  = rdata1_q;
    assign rdata[2]  = fmem[2][frd[2][7:0]];

    always @(posedge rclk) begin
        if (rinc[0]) frd[0] <= frd[0] + 1;
        if (rinc[1]) begin
            rdata1_q <= fmem[1][frd[1][7:0]];
            frd[1]   <= frd[1] + 1;
        end
        if (rinc[2]) frd[2] <= frd[2] + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] i, input logic [7:0] v);
        fmem[i][fwr[i][7:0]] = v;
        fwr[i] = fwr[i] + 1;
    endtask

    task automatic add(input logic [1:0] inst, input logic rdy, input logic e_rinc,
                       input logic e_vld, input logic chk_dat, input logic [7:0] e_dat);
        tbl[n_tbl].inst    = inst;
        tbl[n_tbl].rdy     = rdy;
        tbl[n_tbl].e_rinc  = e_rinc;
        tbl[n_tbl].e_vld   = e_vld;
        tbl[n_tbl].chk_dat = chk_dat;
        tbl[n_tbl].e_dat   = e_dat;
        n_tbl++;
    endtask

    task automatic run_seg(input int first, input int last, output int npulse);
        logic [1:0] i;
        npulse = 0;
        for (int k = first; k <= last; k++) begin
            i = tbl[k].inst;
            m_ready[i] = tbl[k].rdy;
            @(negedge rclk);
            chk($sformatf("row%0d rinc", k), 32'(rinc[i]), 32'(tbl[k].e_rinc));
            chk($sformatf("row%0d m_valid", k), 32'(m_valid[i]), 32'(tbl[k].e_vld));
            if (tbl[k].chk_dat) chk($sformatf("row%0d m_data", k), 32'(m_data[i]), 32'(tbl[k].e_dat));
            if (rinc[i]) npulse++;
            @(posedge rclk);
            #1;
        end
    endtask

    task automatic drive_rand(input logic [1:0] i);
        m_ready[i] = 1'($urandom_range(0, 1));
        if (fwr[i] - base[i] < 200 && $urandom_range(0, 9) < 6) push(i, 8'(fwr[i] - base[i]));
    endtask

    task automatic sample_rand(input logic [1:0] i);
        if (rinc[i] && rempty[i]) viol++;
        if (frd[i] - base[i] - acc_cnt[i] > 2 || frd[i] - base[i] - acc_cnt[i] < 0) viol++;
        if (m_valid[i] && m_ready[i]) begin
            chk($sformatf("rnd%0d word%0d", i, acc_cnt[i]), 32'(m_data[i]), 32'(acc_cnt[i] & 255));
            acc_cnt[i]++;
        end
    endtask

    initial begin
        // Post-reset stream, rd_lat=0: m_valid one cycle after release.
        add(0, 1, 1, 0, 0, 8'h00);
        add(0, 1, 1, 1, 1, 8'h11);
        add(0, 1, 1, 1, 1, 8'h22);
        add(0, 1, 0, 1, 1, 8'h33);
        add(0, 1, 0, 0, 0, 8'h00);
        // rd_lat=1: two cycles from rempty falling to m_valid.
        add(1, 1, 1, 0, 0, 8'h00);
        add(1, 1, 1, 0, 0, 8'h00);
        add(1, 1, 1, 1, 1, 8'h11);
        add(1, 1, 0, 1, 1, 8'h22);
        add(1, 1, 0, 1, 1, 8'h33);
        add(1, 1, 0, 0, 0, 8'h00);
        // Six stalled cycles hold two words, then the buffer drains gap-free.
        add(0, 0, 1, 0, 0, 8'h00);
        add(0, 0, 1, 1, 1, 8'h01);
        for (int k = 0; k < 4; k++) add(0, 0, 0, 1, 1, 8'h01);
        add(0, 1, 1, 1, 1, 8'h01);
        add(0, 1, 1, 1, 1, 8'h02);
        add(0, 1, 1, 1, 1, 8'h03);
        add(0, 1, 0, 1, 1, 8'h04);
        add(0, 1, 0, 1, 1, 8'h05);
        add(0, 1, 0, 0, 0, 8'h00);

        rrst_n  = 1'b0;
        m_ready = 3'b000;
        push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
        #2;
        chk("rst m_valid", 32'(m_valid), 32'(3'b000));
        chk("rst rinc", 32'(rinc), 32'(3'b000));
        chk("rst m_data0", 32'(m_data[0]), 32'h0);
        chk("rst m_data1", 32'(m_data[1]), 32'h0);
        chk("rst rd_count0", 32'(rd_count0), 32'h0);
        chk("rst rd_count2", 32'(rd_count2), 32'h0);
        @(posedge rclk); @(posedge rclk); #1;
        rrst_n = 1'b1;

        run_seg(0, 4, pulses);
        chk("segA rinc pulses", 32'(pulses), 32'd3);
        chk("segA rd_count0", 32'(rd_count0), 32'd3);

        push(1, 8'h11); push(1, 8'h22); push(1, 8'h33);
        run_seg(5, 10, pulses);
        chk("segB rd_count1", 32'(rd_count1), 32'd3);

        for (int k = 1; k <= 5; k++) push(0, 8'(k));
        run_seg(11, 22, pulses);
        chk("segC rinc pulses", 32'(pulses), 32'd5);
        chk("segC rd_count0", 32'(rd_count0), 32'd8);

        // Random back-pressure and bursty FIFO fill on both latency variants.
        for (int j = 0; j < 2; j++) begin
            base[j]    = fwr[j];
            acc_cnt[j] = 0;
        end
        for (int c = 0; c < 4000 && (acc_cnt[0] < 200 || acc_cnt[1] < 200); c++) begin
            for (int j = 0; j < 2; j++) drive_rand(2'(j));
            @(negedge rclk);
            for (int j = 0; j < 2; j++) sample_rand(2'(j));
            @(posedge rclk);
            #1;
        end
        m_ready[0] = 1'b0;
        m_ready[1] = 1'b0;
        chk("rnd words0", 32'(acc_cnt[0]), 32'd200);
        chk("rnd words1", 32'(acc_cnt[1]), 32'd200);
        chk("rnd rule violations", 32'(viol), 32'd0);
        chk("rnd rd_count0", 32'(rd_count0), 32'd208);
        chk("rnd rd_count1", 32'(rd_count1), 32'd203);

        // Narrow counter wraps: 18 deliveries on a 4-bit count.
        for (int k = 0; k < 18; k++) push(2, 8'(32'h40 + k));
        m_ready[2] = 1'b1;
        acc_cnt[2] = 0;
        for (int c = 0; c < 100 && acc_cnt[2] < 18; c++) begin
            @(negedge rclk);
            if (m_valid[2]) begin
                chk($sformatf("wrap word%0d", acc_cnt[2]), 32'(m_data[2]), 32'h40 + 32'(acc_cnt[2]));
                acc_cnt[2]++;
            end
            @(posedge rclk);
            #1;
        end
        m_ready[2] = 1'b0;
        chk("wrap words", 32'(acc_cnt[2]), 32'd18);
        chk("wrap rd_count2", 32'(rd_count2), 32'd2);

        // Reset while both buffers are full: buffered words lost, next FIFO word follows.
        for (int k = 0; k < 5; k++) begin
            push(0, 8'(32'hA0 + k));
            push(1, 8'(32'hA0 + k));
        end
        repeat (5) @(posedge rclk);
        #1;
        @(negedge rclk);
        chk("full m_valid", 32'(m_valid[1:0]), 32'(2'b11));
        chk("full rinc", 32'(rinc[1:0]), 32'(2'b00));
        chk("full m_data1", 32'(m_data[1]), 32'hA0);
        #2;
        rrst_n = 1'b0;
        #1;
        chk("async m_valid", 32'(m_valid[1:0]), 32'(2'b00));
        chk("async rinc", 32'(rinc[1:0]), 32'(2'b00));
        chk("async rd_count0", 32'(rd_count0), 32'h0);
        chk("async rd_count1", 32'(rd_count1), 32'h0);
        @(posedge rclk); @(posedge rclk); #1;
        rrst_n = 1'b1;
        m_ready[0] = 1'b1;
        m_ready[1] = 1'b1;
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;
        repeat (20) begin
            @(negedge rclk);
            for (int j = 0; j < 2; j++) begin
                if (m_valid[j]) begin
                    chk($sformatf("post-rst%0d word%0d", j, acc_cnt[j]), 32'(m_data[j]),
                        32'hA2 + 32'(acc_cnt[j]));
                    acc_cnt[j]++;
                end
            end
            @(posedge rclk);
            #1;
        end
        chk("post-rst words0", 32'(acc_cnt[0]), 32'd3);
        chk("post-rst words1", 32'(acc_cnt[1]), 32'd3);
        chk("post-rst rd_count0", 32'(rd_count0), 32'd3);
        chk("post-rst rd_count1", 32'(rd_count1), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
